// File: rtl/phy_pkg.sv
// Shared PHY definitions: line symbols, byte width and the serializer FSM encoding.
package phy_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] COM_SYM  = 8'hBC;
    localparam logic [BYTE_W-1:0] IDLE_SYM = 8'h7C;

    typedef enum logic {
        ALIGN  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage : phy_pkg

// File: rtl/piso_shift8.sv
// 8-bit parallel-load, shift-left register; q[7] is the bit currently on the line.
module piso_shift8
    import phy_pkg::*;
(
    input  logic              clk32f,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [BYTE_W-1:0] d,
    output logic [BYTE_W-1:0] q
);

    // Load has priority over shift; a zero is shifted in behind the MSB.
    always_ff @(posedge clk32f) begin
        if (reset) begin
            q <= 8'h00;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[BYTE_W-2:0], 1'b0};
        end else begin
            q <= q;
        end
    end

endmodule : piso_shift8

// File: rtl/paralelo_serie_idle.sv
// Transmit byte serializer: N_COM alignment bytes after reset, then handshaked
// data bytes MSB-first with IDLE filling every slot that has no valid byte.
module paralelo_serie_idle
    import phy_pkg::*;
#(
    parameter int unsigned       N_COM = 4,
    parameter logic [BYTE_W-1:0] COM   = COM_SYM,
    parameter logic [BYTE_W-1:0] IDLE  = IDLE_SYM
) (
    input  logic              clk32f,
    input  logic              reset,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready,
    output logic              out,
    output logic              active
);

    localparam logic [3:0] LAST_COM = 4'(N_COM - 1);
    localparam logic [3:0] SAT_COM  = 4'(N_COM);

    state_t            state_r;
    state_t            state_s;
    logic [2:0]        bit_cnt_r;
    logic [3:0]        com_cnt_r;
    logic              run_r;
    logic              ready_r;
    logic              ready_s;
    logic              active_r;
    logic              slot_end_s;
    logic              load_s;
    logic              shift_s;
    logic [BYTE_W-1:0] load_byte_s;
    logic [BYTE_W-1:0] shift_q_s;

    // Slot sequencing, next-byte selection, FSM next state and ready lookahead.
    always_comb begin
        slot_end_s  = run_r && (bit_cnt_r == 3'd7);
        load_s      = 1'b0;
        shift_s     = 1'b0;
        load_byte_s = COM;
        state_s     = state_r;
        ready_s     = 1'b0;

        // The first edge out of reset opens slot 0 without advancing bit_cnt.
        if (!run_r) begin
            load_s      = 1'b1;
            load_byte_s = COM;
        end else if (bit_cnt_r == 3'd7) begin
            load_s = 1'b1;
            if (ready_r) begin
                load_byte_s = valid_in ? data_in : IDLE;
            end else begin
                load_byte_s = COM;
            end
        end else begin
            shift_s = 1'b1;
        end

        case (state_r)
            ALIGN: begin
                if (slot_end_s && (com_cnt_r == LAST_COM)) begin
                    state_s = ACTIVE;
                end else begin
                    state_s = ALIGN;
                end
            end
            ACTIVE:  state_s = ACTIVE;
            default: state_s = ALIGN;
        endcase

        // ready is registered, so it is raised on the edge entering bit 7.
        if (run_r && (bit_cnt_r == 3'd6)) begin
            ready_s = (state_r == ACTIVE) || (com_cnt_r == LAST_COM);
        end else begin
            ready_s = 1'b0;
        end
    end

    // Control registers: FSM state, bit/COM counters and registered flags.
    always_ff @(posedge clk32f) begin
        if (reset) begin
            state_r   <= ALIGN;
            bit_cnt_r <= 3'd0;
            com_cnt_r <= 4'd0;
            run_r     <= 1'b0;
            ready_r   <= 1'b0;
            active_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            run_r    <= 1'b1;
            ready_r  <= ready_s;
            active_r <= (state_s == ACTIVE);
            if (run_r) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (slot_end_s && (state_r == ALIGN) && (com_cnt_r != SAT_COM)) begin
                com_cnt_r <= com_cnt_r + 4'd1;
            end else begin
                com_cnt_r <= com_cnt_r;
            end
        end
    end

    piso_shift8 u_shift (
        .clk32f (clk32f),
        .reset  (reset),
        .load   (load_s),
        .shift  (shift_s),
        .d      (load_byte_s),
        .q      (shift_q_s)
    );

    assign out    = shift_q_s[BYTE_W-1];
    assign ready  = ready_r;
    assign active = active_r;

endmodule : paralelo_serie_idle

// File: tb/tb_paralelo_serie_idle.sv
// Directed bench for paralelo_serie_idle: default instance (N_COM=4) plus an N_COM=1 instance.
module tb_paralelo_serie_idle;

    logic       clk32f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready;
    logic       out;
    logic       active;
    logic       ready1;
    logic       out1;
    logic       active1;

    int n_checks;
    int n_fail;

    paralelo_serie_idle dut (
        .clk32f   (clk32f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready),
        .out      (out),
        .active   (active)
    );

    paralelo_serie_idle #(.N_COM(1)) dut1 (
        .clk32f   (clk32f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready1),
        .out      (out1),
        .active   (active1)
    );

    initial clk32f = 1'b0;
    always #5 clk32f = ~clk32f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe one 8-cycle slot of the N_COM=4 instance; present the next handshake at its first cycle.
    task automatic run_slot(input logic [7:0] exp_byte, input logic exp_act, input logic exp_rdy,
                            input logic nv, input logic [7:0] nd, input string tag);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk32f);
            b = {b[6:0], out};
            check({tag, "_rdy"}, 32'(ready), (k == 7) ? 32'(exp_rdy) : 32'd0);
            if (k == 0) begin
                check({tag, "_act"}, 32'(active), 32'(exp_act));
                valid_in = nv;
                data_in  = nd;
            end
        end
        check(tag, 32'(b), 32'(exp_byte));
    endtask

    initial begin
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] s1;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Reset held: every output stays at its reset value.
        @(posedge clk32f);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk32f);
            check("rst_out", 32'(out), 32'd0);
            check("rst_rdy", 32'(ready), 32'd0);
            check("rst_act", 32'(active), 32'd0);
        end
        reset = 1'b0;

        // Slots 0-1: both instances; N_COM=1 goes ACTIVE after one COM slot.
        b0 = 8'h00;
        s1 = 16'h0000;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk32f);
            b0 = {b0[6:0], out};
            s1 = {s1[14:0], out1};
            check("a_rdy0", 32'(ready), 32'd0);
            check("a_act0", 32'(active), 32'd0);
            check("n1_rdy", 32'(ready1), (c == 7 || c == 15) ? 32'd1 : 32'd0);
            check("n1_act", 32'(active1), (c >= 8) ? 32'd1 : 32'd0);
            if (c == 7) begin
                check("com_s0", 32'(b0), 32'hBC);
                b0 = 8'h00;
            end
        end
        check("com_s1", 32'(b0), 32'hBC);
        check("n1_com", 32'(s1[15:8]), 32'hBC);
        check("n1_idle", 32'(s1[7:0]), 32'h7C);

        run_slot(8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, "com_s2");
        run_slot(8'hBC, 1'b0, 1'b1, 1'b0, 8'h00, "com_s3");

        // Back-to-back data, then IDLE once valid_in drops.
        run_slot(8'h7C, 1'b1, 1'b1, 1'b1, 8'hA5, "idle_s4");
        run_slot(8'hA5, 1'b1, 1'b1, 1'b1, 8'h3C, "d_a5");
        run_slot(8'h3C, 1'b1, 1'b1, 1'b1, 8'hFF, "d_3c");
        run_slot(8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, "d_ff");
        run_slot(8'h7C, 1'b1, 1'b1, 1'b0, 8'h00, "idle_after");

        // valid_in pulsed only away from the ready cycle: never accepted.
        b0 = 8'h00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk32f);
            b0 = {b0[6:0], out};
            if (k == 3) begin
                valid_in = 1'b1;
                data_in  = 8'h77;
            end
            if (k == 5) begin
                valid_in = 1'b0;
            end
        end
        check("glitch_slot", 32'(b0), 32'h7C);
        run_slot(8'h7C, 1'b1, 1'b1, 1'b1, 8'h5A, "glitch_idle");
        run_slot(8'h5A, 1'b1, 1'b1, 1'b1, 8'hBC, "d_5a");

        // Symbols equal to COM/IDLE pass through verbatim.
        run_slot(8'hBC, 1'b1, 1'b1, 1'b1, 8'h7C, "d_bc");
        run_slot(8'h7C, 1'b1, 1'b1, 1'b1, 8'hA5, "d_7c");

        // Reset in the middle of the 0xA5 slot.
        b0 = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk32f);
            b0 = {b0[6:0], out};
        end
        check("pre_rst_bits", 32'(b0[3:0]), 32'hA);
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk32f);
            check("mid_rst_out", 32'(out), 32'd0);
            check("mid_rst_act", 32'(active), 32'd0);
            check("mid_rst_rdy", 32'(ready), 32'd0);
        end
        reset = 1'b0;
        run_slot(8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, "re_com0");
        run_slot(8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, "re_com1");
        run_slot(8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, "re_com2");
        run_slot(8'hBC, 1'b0, 1'b1, 1'b1, 8'hC3, "re_com3");
        run_slot(8'hC3, 1'b1, 1'b1, 1'b0, 8'h00, "re_data");
        run_slot(8'h7C, 1'b1, 1'b1, 1'b0, 8'h00, "re_idle");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule : tb_paralelo_serie_idle
